decode_imm_stage: RTL and testbench



---
 rtl/rv32i_pkg.sv | 53 +++++
 rtl/imm_assembler.sv | 70 +++++++
 rtl/decode_imm_stage.sv | 125 ++++++++++++
 tb/tb_decode_imm_stage.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_pkg.sv
// ============================================================================
// Module      : rv32i_pkg
// Description : Shared RV32I decode definitions: major opcode constants, the
//               instruction-format enumeration and the decoded-entry record
//               carried through the decode stage storage registers.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package rv32i_pkg;

  // Width of the PC field held inside a decoded entry. The decode stage PC_W
  // parameter must match this value.
  localparam int unsigned c_DEC_PC_W = 32;

  // RV32I major opcodes (instr[6:0])
  localparam logic [6:0] c_OP_LUI    = 7'b0110111;
  localparam logic [6:0] c_OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] c_OP_JAL    = 7'b1101111;
  localparam logic [6:0] c_OP_JALR   = 7'b1100111;
  localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
  localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
  localparam logic [6:0] c_OP_STORE  = 7'b0100011;
  localparam logic [6:0] c_OP_IMM    = 7'b0010011;
  localparam logic [6:0] c_OP_REG    = 7'b0110011;
  localparam logic [6:0] c_OP_FENCE  = 7'b0001111;
  localparam logic [6:0] c_OP_SYSTEM = 7'b1110011;

  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5
  } fmt_e;

  typedef struct packed {
    logic [c_DEC_PC_W-1:0] pc;
    logic [6:0]            opcode;
    logic [4:0]            rd;
    logic [4:0]            rs1;
    logic [4:0]            rs2;
    logic [2:0]            funct3;
    logic [6:0]            funct7;
    fmt_e                  fmt;
    logic [31:0]           imm;
    logic                  illegal;
  } dec_entry_t;

endpackage

`default_nettype wire

// File: rtl/imm_assembler.sv
// ============================================================================
// Module      : imm_assembler
// Description : Combinational RV32I format classifier and immediate builder.
//   instr   in  32 : raw instruction word
//   fmt     out 3  : format code (R=0 I=1 S=2 B=3 U=4 J=5)
//   imm     out 32 : sign-extended immediate (0 for R and illegal)
//   illegal out 1  : unrecognised opcode or low bits not 2'b11
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module imm_assembler
  import rv32i_pkg::*;
(
  input  logic [31:0] instr,
  output logic [2:0]  fmt,
  output logic [31:0] imm,
  output logic        illegal
);

  fmt_e w_fmt;
  logic w_s;

  assign w_s = instr[31];
  assign fmt = w_fmt;

  always_comb begin
    w_fmt   = FMT_R;
    imm     = 32'h0;
    illegal = 1'b0;
    case (instr[6:0])
      c_OP_LUI, c_OP_AUIPC: begin
        w_fmt = FMT_U;
        imm   = {instr[31:12], 12'b0};
      end
      c_OP_JAL: begin
        w_fmt = FMT_J;
        imm   = {{11{w_s}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      end
      c_OP_JALR, c_OP_LOAD, c_OP_IMM, c_OP_FENCE, c_OP_SYSTEM: begin
        w_fmt = FMT_I;
        imm   = {{20{w_s}}, instr[31:20]};
      end
      c_OP_BRANCH: begin
        w_fmt = FMT_B;
        imm   = {{19{w_s}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      end
      c_OP_STORE: begin
        w_fmt = FMT_S;
        imm   = {{20{w_s}}, instr[31:25], instr[11:7]};
      end
      c_OP_REG: begin
        w_fmt = FMT_R;
      end
      default: begin
        illegal = 1'b1;
      end
    endcase
    // Compressed/reserved encodings: every listed opcode already ends in
    // 2'b11, this keeps the rule explicit should the table grow.
    if (instr[1:0] != 2'b11) begin
      w_fmt   = FMT_R;
      imm     = 32'h0;
      illegal = 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/decode_imm_stage.sv
// ============================================================================
// Module      : decode_imm_stage
// Description : Registered RV32I decode stage with a one-entry skid buffer.
//   clk, rst (sync, active-high), flush (drop all held/in-flight entries)
//   in_valid/in_ready/in_instr/in_pc : upstream valid/ready handshake
//   out_valid/out_ready              : downstream valid/ready handshake
//   out_pc, out_opcode, out_rd, out_rs1, out_rs2, out_funct3, out_funct7 :
//       raw fields of the held instruction
//   out_fmt, out_imm, out_illegal    : decoded format / immediate / illegal
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module decode_imm_stage
  import rv32i_pkg::*;
#(
  parameter int PC_W = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [PC_W-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [PC_W-1:0] out_pc,
  output logic [6:0]      out_opcode,
  output logic [4:0]      out_rd,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [2:0]      out_funct3,
  output logic [6:0]      out_funct7,
  output logic [2:0]      out_fmt,
  output logic [31:0]     out_imm,
  output logic            out_illegal
);

  dec_entry_t  r_main;
  dec_entry_t  r_skid;
  logic        r_main_valid;
  logic        r_skid_valid;

  dec_entry_t  w_new;
  logic [2:0]  w_asm_fmt;
  logic [31:0] w_asm_imm;
  logic        w_asm_illegal;
  logic        w_accept;
  logic        w_main_free;

  imm_assembler u_imm_assembler (
    .instr   (in_instr),
    .fmt     (w_asm_fmt),
    .imm     (w_asm_imm),
    .illegal (w_asm_illegal)
  );

  always_comb begin
    w_new         = '0;
    w_new.pc      = in_pc;
    w_new.opcode  = in_instr[6:0];
    w_new.rd      = in_instr[11:7];
    w_new.rs1     = in_instr[19:15];
    w_new.rs2     = in_instr[24:20];
    w_new.funct3  = in_instr[14:12];
    w_new.funct7  = in_instr[31:25];
    w_new.fmt     = fmt_e'(w_asm_fmt);
    w_new.imm     = w_asm_imm;
    w_new.illegal = w_asm_illegal;
  end

  // in_ready comes straight off the skid valid flop, so it never depends
  // combinationally on out_ready.
  assign in_ready    = !r_skid_valid;
  assign w_accept    = in_valid && in_ready;
  // Main can take a new entry this cycle if it is empty or being consumed.
  assign w_main_free = !r_main_valid || out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_main       <= '0;
      r_skid       <= '0;
      r_main_valid <= 1'b0;
      r_skid_valid <= 1'b0;
    end else if (flush) begin
      r_main_valid <= 1'b0;
      r_skid_valid <= 1'b0;
    end else if (w_main_free) begin
      if (r_skid_valid) begin
        // Older skid entry goes first; a same-cycle input backfills skid.
        r_main       <= r_skid;
        r_main_valid <= 1'b1;
        if (w_accept) begin
          r_skid <= w_new;
        end
        r_skid_valid <= w_accept;
      end else if (w_accept) begin
        r_main       <= w_new;
        r_main_valid <= 1'b1;
      end else begin
        r_main_valid <= 1'b0;
      end
    end else if (w_accept) begin
      // Main is stalled: park the new entry so upstream is not stalled too.
      r_skid       <= w_new;
      r_skid_valid <= 1'b1;
    end
  end

  assign out_valid   = r_main_valid;
  assign out_pc      = r_main.pc;
  assign out_opcode  = r_main.opcode;
  assign out_rd      = r_main.rd;
  assign out_rs1     = r_main.rs1;
  assign out_rs2     = r_main.rs2;
  assign out_funct3  = r_main.funct3;
  assign out_funct7  = r_main.funct7;
  assign out_fmt     = r_main.fmt;
  assign out_imm     = r_main.imm;
  assign out_illegal = r_main.illegal;

endmodule

`default_nettype wire

// File: tb/tb_decode_imm_stage.sv
// ============================================================================
// Module      : tb_decode_imm_stage
// Description : Self-checking bench for decode_imm_stage: table of directed
//               decode vectors plus backpressure, flush and reset sequences.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_decode_imm_stage;

  typedef struct {
    logic [31:0] instr;
    logic [2:0]  fmt;
    logic [31:0] imm;
    logic        ill;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
  } vec_t;

  localparam int c_NVEC = 11;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [6:0]  out_opcode;
  logic [4:0]  out_rd;
  logic [4:0]  out_rs1;
  logic [4:0]  out_rs2;
  logic [2:0]  out_funct3;
  logic [6:0]  out_funct7;
  logic [2:0]  out_fmt;
  logic [31:0] out_imm;
  logic        out_illegal;

  int   n_tests;
  int   n_fail;
  vec_t vecs [c_NVEC];

  decode_imm_stage #(.PC_W(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_instr    (in_instr),
    .in_pc       (in_pc),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_pc      (out_pc),
    .out_opcode  (out_opcode),
    .out_rd      (out_rd),
    .out_rs1     (out_rs1),
    .out_rs2     (out_rs2),
    .out_funct3  (out_funct3),
    .out_funct7  (out_funct7),
    .out_fmt     (out_fmt),
    .out_imm     (out_imm),
    .out_illegal (out_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [31:0] i, input logic [2:0] f, input logic [31:0] im,
                              input logic il, input logic [4:0] rd, input logic [4:0] rs1,
                              input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7);
    vec_t v;
    v.instr = i; v.fmt = f; v.imm = im; v.ill = il;
    v.rd = rd; v.rs1 = rs1; v.rs2 = rs2; v.f3 = f3; v.f7 = f7;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] instr, input logic [31:0] pc);
    in_valid = 1'b1;
    in_instr = instr;
    in_pc    = pc;
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    int   idx;
    int   got;
    logic saw_lo;
    logic [31:0] op;

    n_tests = 0;
    n_fail  = 0;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0; out_ready = 1'b1;

    //              instr         fmt   imm           ill rd  rs1 rs2 f3  f7
    vecs[0]  = mk(32'hFFF00093, 3'd1, 32'hFFFFFFFF, 0,  1,  0, 31, 0, 7'h7F);
    vecs[1]  = mk(32'hFE112E23, 3'd2, 32'hFFFFFFFC, 0, 28,  2,  1, 2, 7'h7F);
    vecs[2]  = mk(32'h80000063, 3'd3, 32'hFFFFF000, 0,  0,  0,  0, 0, 7'h40);
    vecs[3]  = mk(32'h800000EF, 3'd5, 32'hFFF00000, 0,  1,  0,  0, 0, 7'h40);
    vecs[4]  = mk(32'h12345037, 3'd4, 32'h12345000, 0,  0,  8,  3, 5, 7'h09);
    vecs[5]  = mk(32'h00000000, 3'd0, 32'h00000000, 1,  0,  0,  0, 0, 7'h00);
    vecs[6]  = mk(32'h0000007F, 3'd0, 32'h00000000, 1,  0,  0,  0, 0, 7'h00);
    vecs[7]  = mk(32'h002081B3, 3'd0, 32'h00000000, 0,  3,  1,  2, 0, 7'h00);
    vecs[8]  = mk(32'h00001017, 3'd4, 32'h00001000, 0,  0,  0,  0, 1, 7'h00);
    vecs[9]  = mk(32'h00000003, 3'd1, 32'h00000000, 0,  0,  0,  0, 0, 7'h00);
    vecs[10] = mk(32'h00000001, 3'd0, 32'h00000000, 1,  0,  0,  0, 0, 7'h00);

    // Reset state
    tick(); tick();
    rst = 1'b0;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_out_imm", out_imm, 0);
    chk("rst_out_fmt", 32'(out_fmt), 0);
    chk("rst_out_illegal", 32'(out_illegal), 0);
    chk("rst_out_pc", out_pc, 0);
    chk("rst_out_rd", 32'(out_rd), 0);

    // Decode table: each vector visible one cycle after its accept
    for (int i = 0; i < c_NVEC; i++) begin
      in_valid = 1'b1;
      in_instr = vecs[i].instr;
      in_pc    = 32'h1000 + 32'(i * 4);
      tick();
      op = vecs[i].instr;
      chk($sformatf("v%0d_valid", i), 32'(out_valid), 1);
      chk($sformatf("v%0d_pc", i), out_pc, 32'h1000 + 32'(i * 4));
      chk($sformatf("v%0d_opcode", i), 32'(out_opcode), 32'(op[6:0]));
      chk($sformatf("v%0d_fmt", i), 32'(out_fmt), 32'(vecs[i].fmt));
      chk($sformatf("v%0d_imm", i), out_imm, vecs[i].imm);
      chk($sformatf("v%0d_illegal", i), 32'(out_illegal), 32'(vecs[i].ill));
      chk($sformatf("v%0d_rd", i), 32'(out_rd), 32'(vecs[i].rd));
      chk($sformatf("v%0d_rs1", i), 32'(out_rs1), 32'(vecs[i].rs1));
      chk($sformatf("v%0d_rs2", i), 32'(out_rs2), 32'(vecs[i].rs2));
      chk($sformatf("v%0d_funct3", i), 32'(out_funct3), 32'(vecs[i].f3));
      chk($sformatf("v%0d_funct7", i), 32'(out_funct7), 32'(vecs[i].f7));
    end
    in_valid = 1'b0;
    tick();
    chk("drain_empty", 32'(out_valid), 0);

    // Stream of 4 with out_ready low for 3 cycles mid-stream
    idx = 0; got = 0; saw_lo = 1'b0;
    for (int cyc = 0; cyc < 40 && got < 4; cyc++) begin
      out_ready = !(cyc >= 2 && cyc < 5);
      in_valid  = (idx < 4);
      in_instr  = vecs[(idx < 4) ? idx : 0].instr;
      in_pc     = 32'h200 + 32'(idx * 4);
      if (!in_ready) saw_lo = 1'b1;
      if (out_valid && out_ready) begin
        chk($sformatf("stream%0d_pc", got), out_pc, 32'h200 + 32'(got * 4));
        chk($sformatf("stream%0d_imm", got), out_imm, vecs[got].imm);
        got++;
      end
      if (in_valid && in_ready) idx++;
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    chk("stream_count", 32'(got), 4);
    chk("stream_ready_dropped", 32'(saw_lo), 1);
    chk("stream_no_dup", 32'(out_valid), 0);

    // Flush with main and skid full while in_valid high
    out_ready = 1'b0;
    push(vecs[0].instr, 32'h300);
    push(vecs[1].instr, 32'h304);
    chk("full_in_ready", 32'(in_ready), 0);
    chk("full_out_pc", out_pc, 32'h300);
    flush = 1'b1; in_valid = 1'b1; in_instr = vecs[2].instr; in_pc = 32'h308;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush1_out_valid", 32'(out_valid), 0);
    chk("flush1_in_ready", 32'(in_ready), 1);
    out_ready = 1'b1;
    tick();
    chk("flush1_gone_a", 32'(out_valid), 0);
    tick();
    chk("flush1_gone_b", 32'(out_valid), 0);

    // Flush with main held and skid empty: the flush-cycle input would go to skid
    out_ready = 1'b0;
    push(vecs[3].instr, 32'h310);
    chk("flush2_pre_ready", 32'(in_ready), 1);
    flush = 1'b1; in_valid = 1'b1; in_instr = vecs[4].instr; in_pc = 32'h314;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush2_out_valid", 32'(out_valid), 0);
    out_ready = 1'b1;
    tick();
    chk("flush2_gone", 32'(out_valid), 0);
    push(vecs[0].instr, 32'h318);
    chk("post_flush_valid", 32'(out_valid), 1);
    chk("post_flush_pc", out_pc, 32'h318);
    tick();

    // Reset mid-operation with both entries held
    out_ready = 1'b0;
    push(vecs[1].instr, 32'h400);
    push(vecs[2].instr, 32'h404);
    rst = 1'b1; in_valid = 1'b1; in_instr = vecs[3].instr; in_pc = 32'h408;
    tick();
    rst = 1'b0; in_valid = 1'b0;
    chk("midrst_out_valid", 32'(out_valid), 0);
    chk("midrst_in_ready", 32'(in_ready), 1);
    chk("midrst_out_pc", out_pc, 0);
    out_ready = 1'b1;
    tick();
    chk("midrst_empty", 32'(out_valid), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
